// File: rtl/busca_instrucao.sv
// Instruction fetch unit: walks a ROM from a program counter into a 2-deep
// {address, instruction} buffer, with jump redirection and a halt state.
module busca_instrucao #(
    parameter logic [7:0] ENDERECO_INICIAL = 8'd0,
    parameter logic [7:0] ENDERECO_FINAL   = 8'd31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       habilitar,
    output logic [7:0] ler_endereco,
    input  logic [7:0] instrucao_in,
    input  logic       salto_valido,
    input  logic [7:0] salto_endereco,
    input  logic       pronto_in,
    output logic       valido_out,
    output logic [7:0] instrucao_out,
    output logic [7:0] pc_out,
    output logic       parado_out
);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] BUSCA  = 2'd1;
    localparam logic [1:0] PARADO = 2'd2;

    logic [1:0]      estado_q, estado_d;
    logic [7:0]      pc_q, pc_d;
    logic [1:0]      cont_q, cont_d;
    logic [1:0][7:0] end_q, end_d;
    logic [1:0][7:0] instr_q, instr_d;

    logic pop;
    logic busca;
    logic slot;

    // A fetch only looks at the pre-pop occupancy, so a full buffer never
    // accepts a word even on the cycle it drains one.
    always_comb begin
        pop   = (cont_q != 2'd0) && pronto_in;
        busca = (estado_q == BUSCA) && habilitar && (cont_q != 2'd2);
        slot  = cont_q[0] & ~pop;
    end

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        cont_d   = cont_q;
        end_d    = end_q;
        instr_d  = instr_q;
        if (salto_valido) begin
            cont_d   = 2'd0;
            pc_d     = salto_endereco;
            estado_d = BUSCA;
        end else begin
            if (pop) begin
                end_d[0]   = end_q[1];
                instr_d[0] = instr_q[1];
            end
            if (busca) begin
                end_d[slot]   = pc_q;
                instr_d[slot] = instrucao_in;
                pc_d          = pc_q + 8'd1;
                if (pc_q == ENDERECO_FINAL) begin
                    estado_d = PARADO;
                end
            end
            cont_d = cont_q - {1'b0, pop} + {1'b0, busca};
            if ((estado_q == OCIOSO) && habilitar) begin
                estado_d = BUSCA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= OCIOSO;
            pc_q     <= ENDERECO_INICIAL;
            cont_q   <= 2'd0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            cont_q   <= cont_d;
        end
    end

    // Buffer payload is qualified by cont_q, so it needs no reset.
    always_ff @(posedge clk) begin
        end_q   <= end_d;
        instr_q <= instr_d;
    end

    always_comb begin
        ler_endereco  = pc_q;
        valido_out    = (cont_q != 2'd0);
        instrucao_out = valido_out ? instr_q[0] : 8'h00;
        pc_out        = valido_out ? end_q[0] : 8'h00;
        parado_out    = (estado_q == PARADO);
    end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 Parameter ENDERECO_INICIAL, default 8'd0, PC value loaded on reset.
REQ-002 Parameter ENDERECO_FINAL, default 8'd31, address of the last program word; fetching stops after it.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 habilitar  input  1  fetch enable; leaves OCIOSO and gates fetches.
REQ-006 ler_endereco  output  8  ROM read address, driven directly from PC register.
REQ-007 instrucao_in  input  8  ROM data; combinational function of ler_endereco in the same cycle.
REQ-008 salto_valido  input  1  one-cycle jump request.
REQ-009 salto_endereco  input  8  jump target, sampled when salto_valido=1.
REQ-010 pronto_in  input  1  consumer ready.
REQ-011 valido_out  output  1  head of buffer holds a valid instruction.
REQ-012 instrucao_out  output  8  instruction at buffer head.
REQ-013 pc_out  output  8  address from which instrucao_out was fetched.
REQ-014 parado_out  output  1  high while in state PARADO.

Function
REQ-015 Block SHALL hold PC (8 bit), a 2-entry FIFO of {address, instruction}, an occupancy count 0..2, and FSM states OCIOSO, BUSCA, PARADO.
REQ-016 valido_out SHALL equal (count != 0); instrucao_out/pc_out SHALL show FIFO head, 8'h00 when empty.
REQ-017 Pop SHALL occur on an edge where valido_out=1 and pronto_in=1.
REQ-018 OCIOSO: no fetch; habilitar=1 SHALL move to BUSCA with no fetch in that cycle.
REQ-019 BUSCA: fetch SHALL occur when habilitar=1 and count<2 (pre-pop count; no fetch into a full FIFO even if popping).
REQ-020 Fetch SHALL push {PC, instrucao_in} and set PC to PC+1 modulo 256.
REQ-021 Fetch with PC == ENDERECO_FINAL SHALL push that word and move to PARADO; PC becomes ENDERECO_FINAL+1 (mod 256).
REQ-022 BUSCA with habilitar=0 SHALL hold PC; FIFO still drains.
REQ-023 PARADO: no fetch; FIFO drains normally; exit only via salto or reset.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, head advances, new entry appended.
REQ-025 salto_valido=1 SHALL have highest priority: FIFO flushed (count=0, no pop counted), PC <= salto_endereco, state <= BUSCA from any state, no fetch that cycle.
REQ-026 First fetch after a jump SHALL occur on the next cycle with habilitar=1, at salto_endereco.
REQ-027 Fetch throughput SHALL be one word per cycle when pronto_in is held high (steady count=1).
REQ-028 Latency: instruction fetched on edge N SHALL appear on instrucao_out immediately after edge N if FIFO was empty.

Reset
REQ-029 reset=1 at an edge SHALL set PC=ENDERECO_INICIAL, count=0, state=OCIOSO, regardless of in-progress fetch, jump or pop.
REQ-030 After reset: ler_endereco=ENDERECO_INICIAL, valido_out=0, instrucao_out=8'h00, pc_out=8'h00, parado_out=0.
REQ-031 reset SHALL take priority over salto_valido.

Verification (bench ROM model: word[a] = a XOR 8'hA5)
REQ-032 Reset, habilitar=1, pronto_in=1 -> valido_out from 2nd cycle after habilitar; stream pc_out 0..31 with instrucao_out 8'hA5, 8'hA4, ... 8'hBA, one per cycle; then parado_out=1, valido_out=0.
REQ-033 pronto_in=0 after start -> count saturates at 2, ler_endereco holds 8'h02, head stays {8'h00, 8'hA5}; pronto_in=1 resumes with no lost/duplicated words.
REQ-034 salto_valido=1, salto_endereco=8'h10 mid-stream with full FIFO -> next cycle valido_out=0, ler_endereco=8'h10; following cycle head {8'h10, 8'hB5}.
REQ-035 In PARADO, salto_endereco=8'h1E -> parado_out=0, words 8'h1E, 8'h1F delivered, then PARADO again.
REQ-036 ENDERECO_FINAL=8'hFF, jump to 8'hFE -> words 8'hFE, 8'hFF, then PARADO with ler_endereco=8'h00 (wrap).
REQ-037 reset asserted with salto_valido=1 and count=2 -> state OCIOSO, count=0, ler_endereco=8'h00.
